// File: rtl/rr_pop_scheduler_pkg.sv
// rr_pkg: shared constants, FSM state type, schedule-table type and helpers
// for the round-robin pop scheduler.
package rr_pkg;

    localparam int unsigned RR_NUM_Q = 4;   // FIFOs scheduled
    localparam int unsigned RR_SLOTS = 10;  // schedule-table entries
    localparam int unsigned RR_ID_W  = 2;   // FIFO id width, clog2(RR_NUM_Q)
    localparam int unsigned RR_PTR_W = 4;   // slot pointer width, 2**RR_PTR_W >= RR_SLOTS

    typedef enum logic [1:0] {
        RR_IDLE = 2'd0,
        RR_LOAD = 2'd1,
        RR_RUN  = 2'd2
    } rr_state_t;

    // Slot i occupies bits [ID_W*i +: ID_W], slot 0 in the LSBs.
    typedef logic [RR_SLOTS-1:0][RR_ID_W-1:0] rr_table_t;

    // Reset pattern: slot i serves FIFO i mod NUM_Q.
    function automatic rr_table_t rr_default_table();
        rr_table_t t;
        for (int unsigned i = 0; i < RR_SLOTS; i++) begin
            t[i] = RR_ID_W'(i % RR_NUM_Q);
        end
        return t;
    endfunction

    // Slot pointer increment with wrap at SLOTS-1.
    function automatic logic [RR_PTR_W-1:0] rr_next_slot(input logic [RR_PTR_W-1:0] s);
        return (s == RR_PTR_W'(RR_SLOTS - 1)) ? '0 : s + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pop_scheduler_if.sv
// rr_pop_scheduler_if: config, FIFO-status and pop signals of the scheduler.
//   slave  : scheduler view (cfg/enable/empty/pause in, pop/pop_id/slot_ptr/cfg_busy out)
//   master : environment view (drives config and FIFO status, observes pops)
interface rr_pop_scheduler_if;
    import rr_pkg::*;

    logic                         cfg_load;
    logic [RR_SLOTS*RR_ID_W-1:0]  cfg_table;
    logic                         enable;
    logic [RR_NUM_Q-1:0]          empty;
    logic                         pause;
    logic                         pop;
    logic [RR_ID_W-1:0]           pop_id;
    logic [RR_PTR_W-1:0]          slot_ptr;
    logic                         cfg_busy;

    modport slave (
        input  cfg_load, cfg_table, enable, empty, pause,
        output pop, pop_id, slot_ptr, cfg_busy
    );

    modport master (
        output cfg_load, cfg_table, enable, empty, pause,
        input  pop, pop_id, slot_ptr, cfg_busy
    );

endinterface

// File: rtl/rr_pop_scheduler_slot_search.sv
// rr_slot_search: combinational pick of the slot to serve this cycle.
//   Inputs : tbl (schedule table), empty (per-FIFO flags), slot_ptr (current slot)
//   Outputs: hit (slot has a non-empty FIFO), hit_slot, hit_id
// Build option RR_SKIP_EMPTY_EN: scan all slots starting at slot_ptr and return
// the first non-empty one; otherwise only slot_ptr is examined.
module rr_slot_search
    import rr_pkg::*;
(
    input  rr_table_t            tbl,
    input  logic [RR_NUM_Q-1:0]  empty,
    input  logic [RR_PTR_W-1:0]  slot_ptr,
    output logic                 hit,
    output logic [RR_PTR_W-1:0]  hit_slot,
    output logic [RR_ID_W-1:0]   hit_id
);

`ifdef RR_SKIP_EMPTY_EN
    // One extra bit so slot_ptr + offset cannot overflow before the modulo.
    localparam int unsigned SUM_W = RR_PTR_W + 1;

    logic [SUM_W-1:0] idx;

    // Rotated first-hit scan over all slots.
    always_comb begin
        hit      = 1'b0;
        hit_slot = slot_ptr;
        hit_id   = tbl[slot_ptr];
        idx      = '0;
        for (int unsigned k = 0; k < RR_SLOTS; k++) begin
            idx = SUM_W'(slot_ptr) + SUM_W'(k);
            if (idx >= SUM_W'(RR_SLOTS)) begin
                idx = idx - SUM_W'(RR_SLOTS);
            end
            if (!hit && !empty[tbl[idx[RR_PTR_W-1:0]]]) begin
                hit      = 1'b1;
                hit_slot = idx[RR_PTR_W-1:0];
                hit_id   = tbl[idx[RR_PTR_W-1:0]];
            end
        end
    end
`else
    // Strict walk: only the current slot is a candidate.
    assign hit_slot = slot_ptr;
    assign hit_id   = tbl[slot_ptr];
    assign hit      = !empty[hit_id];
`endif

endmodule

// File: rtl/rr_pop_scheduler.sv
// rr_pop_scheduler: table-driven round-robin pop scheduler for the FIFO bank.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : rr_pop_scheduler_if.slave
//           in : cfg_load, cfg_table, enable, empty, pause
//           out: pop, pop_id (held when pop=0), slot_ptr, cfg_busy (all registered)
// Build option RR_SKIP_EMPTY_EN: work-conserving mode, skipping slots whose
// FIFO is empty within the same cycle; default walks one slot per cycle.
module rr_pop_scheduler
    import rr_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    rr_pop_scheduler_if.slave    bus
);

    rr_state_t             state_q, state_d;
    rr_table_t             tbl_q, tbl_d;
    logic [RR_PTR_W-1:0]   slot_ptr_q, slot_ptr_d;
    logic                  pop_q, pop_d;
    logic [RR_ID_W-1:0]    pop_id_q, pop_id_d;
    logic                  cfg_busy_q, cfg_busy_d;

    logic                  search_hit;
    logic [RR_PTR_W-1:0]   search_slot;
    logic [RR_ID_W-1:0]    search_id;

    // Candidate slot selection.
    rr_slot_search u_search (
        .tbl      (tbl_q),
        .empty    (bus.empty),
        .slot_ptr (slot_ptr_q),
        .hit      (search_hit),
        .hit_slot (search_slot),
        .hit_id   (search_id)
    );

    // State, table and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RR_IDLE;
            tbl_q      <= rr_default_table();
            slot_ptr_q <= '0;
            pop_q      <= 1'b0;
            pop_id_q   <= '0;
            cfg_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tbl_q      <= tbl_d;
            slot_ptr_q <= slot_ptr_d;
            pop_q      <= pop_d;
            pop_id_q   <= pop_id_d;
            cfg_busy_q <= cfg_busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        tbl_d      = tbl_q;
        slot_ptr_d = slot_ptr_q;
        pop_d      = 1'b0;
        pop_id_d   = pop_id_q;
        cfg_busy_d = 1'b0;

        unique case (state_q)
            RR_IDLE: begin
                if (bus.cfg_load) begin
                    state_d = RR_LOAD;
                end else if (bus.enable) begin
                    state_d = RR_RUN;
                end
            end
            RR_LOAD: begin
                // A still-high cfg_load re-enters LOAD so the last table wins.
                if (bus.cfg_load) begin
                    state_d = RR_LOAD;
                end else if (bus.enable) begin
                    state_d = RR_RUN;
                end else begin
                    state_d = RR_IDLE;
                end
            end
            RR_RUN: begin
                if (bus.cfg_load) begin
                    state_d = RR_LOAD;
                end else if (!bus.enable) begin
                    state_d = RR_IDLE;
                end else if (!bus.pause) begin
                    if (search_hit) begin
                        pop_d    = 1'b1;
                        pop_id_d = search_id;
                    end
`ifdef RR_SKIP_EMPTY_EN
                    // Resume after the granted slot; hold if nothing is ready.
                    if (search_hit) begin
                        slot_ptr_d = rr_next_slot(search_slot);
                    end
`else
                    slot_ptr_d = rr_next_slot(slot_ptr_q);
`endif
                end
            end
            default: begin
                state_d = RR_IDLE;
            end
        endcase

        // Table capture happens on entry to LOAD; the pending slot is dropped.
        if (state_d == RR_LOAD) begin
            tbl_d      = bus.cfg_table;
            slot_ptr_d = '0;
            pop_d      = 1'b0;
            cfg_busy_d = 1'b1;
        end
    end

    assign bus.pop      = pop_q;
    assign bus.pop_id   = pop_id_q;
    assign bus.slot_ptr = slot_ptr_q;
    assign bus.cfg_busy = cfg_busy_q;

endmodule

// File: doc/rr_pop_scheduler.md
Name: rr_pop_scheduler

Overview:
- Table-driven round-robin pop scheduler for the 4 output-port FIFOs of the switch datapath.
- Holds a 10-slot programmable schedule table (2-bit FIFO id per slot) and walks it one slot per cycle.
- Issues a registered pop strobe plus FIFO id when the scheduled FIFO is non-empty and downstream is not paused.
- Sits between the FIFO bank (empty flags in) and the FIFO read-mux (pop/pop_id out); configured by the test/config block.

Parameters:
- NUM_Q, 4, number of FIFOs scheduled.
- SLOTS, 10, number of schedule-table entries.
- ID_W, 2, FIFO id width; must equal clog2(NUM_Q).
- PTR_W, 4, slot-pointer width; must satisfy 2**PTR_W >= SLOTS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_load  in  1  one-cycle strobe; capture cfg_table.
- cfg_table  in  SLOTS*ID_W (20)  slot i = cfg_table[2i+1:2i], slot 0 in LSBs.
- enable  in  1  level; scheduler runs while high.
- empty  in  NUM_Q  empty flag per FIFO, bit n = FIFO n.
- pause  in  1  downstream almost-full; stall scheduling.
- pop  out  1  registered pop strobe to the FIFO read-mux.
- pop_id  out  ID_W  FIFO being popped; holds last value when pop=0.
- slot_ptr  out  PTR_W  current table index (debug/verification).
- cfg_busy  out  1  high during the LOAD cycle.

Behaviour:
- Reset (reset=0, async): state=IDLE; slot_ptr=0; pop=0; pop_id=0; cfg_busy=0; table[i] = i mod NUM_Q, giving 0,1,2,3,0,1,2,3,0,1.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - cfg_load=1 -> LOAD.
  - else enable=1 -> RUN.
  - pop=0.
- LOAD (exactly 1 cycle):
  - table <= cfg_table; slot_ptr <= 0; pop=0; cfg_busy=1.
  - Next state: RUN if enable=1, else IDLE.
- RUN, priority order per cycle:
  1. cfg_load=1 -> LOAD. No pop is issued that cycle; the pending slot is discarded.
  2. enable=0 -> IDLE. slot_ptr holds; pop=0.
  3. pause=1 -> slot_ptr holds; pop=0.
  4. Otherwise evaluate id = table[slot_ptr]:
     - empty[id]=0: next edge pop=1 and pop_id=id.
     - empty[id]=1: pop=0.
     - In both cases slot_ptr advances by 1; SLOTS-1 wraps to 0.
- Latency: evaluation in cycle N -> pop/pop_id valid in cycle N+1, for exactly one cycle per grant.
- Throughput: at most one pop per cycle. Back-to-back pops are allowed, including the same id in consecutive slots.
- The FIFO bank guarantees empty reflects the previous pop within one cycle. The scheduler does not track in-flight pops.
- Boundary conditions:
  - All FIFOs empty: pointer keeps cycling, pop stays 0.
  - cfg_load held high for multiple cycles: one LOAD per rising edge of cfg_load is not required. Every cycle with cfg_load=1 re-enters LOAD, so the last captured table wins.
  - cfg_load and pause together: cfg_load wins.
  - Reset mid-RUN: outputs clear immediately (asynchronous) and the table returns to its default.
  - Table entries never exceed NUM_Q-1 because the field is ID_W bits wide. No range checking is needed.

Optional Feature:
- Macro: RR_SKIP_EMPTY_EN.
- Defined (work-conserving):
  - In RUN with pause=0, search the slots in order slot_ptr, slot_ptr+1, ... (modulo SLOTS), covering all SLOTS entries in one cycle.
  - Grant the first slot whose FIFO is non-empty; pop/pop_id as above.
  - slot_ptr <= granted slot + 1, wrapping.
  - If no slot is non-empty: pop=0, slot_ptr holds.
- Undefined: one slot per cycle, as in Behaviour. Empty slots burn a cycle.

Decomposition:
- Shared package rr_pkg holds:
  - constants RR_NUM_Q=4, RR_SLOTS=10, RR_ID_W=2, RR_PTR_W=4;
  - state typedef rr_state_t {RR_IDLE, RR_LOAD, RR_RUN};
  - default table pattern function.
- One sub-module, rr_slot_search (combinational). Inputs: table, empty, slot_ptr. Outputs: hit, hit_slot, hit_id.
  - Without RR_SKIP_EMPTY_EN it checks only slot_ptr.
  - With RR_SKIP_EMPTY_EN it performs the rotated first-hit scan.
- All state, the table registers and the output registers stay in rr_pop_scheduler.

Test Plan:
- Reset default: release reset, enable=1, empty=4'b0000, pause=0 -> from the cycle after entering RUN, pop=1 every cycle with pop_id sequence 0,1,2,3,0,1,2,3,0,1,0,...; slot_ptr wraps 9->0.
- Custom table: cfg_table gives slots 0..9 = 3,3,0,1,3,2,3,0,3,1, all non-empty -> cfg_busy=1 for one cycle, then pop_id follows 3,3,0,1,3,2,3,0,3,1 repeating.
- Empty masking: default table, empty=4'b0100 (FIFO 2 empty):
  - macro off -> pop=0 in the cycles for slots 2 and 6, pointer still advances.
  - macro on -> pop_ids 0,1,3,0,1,3,0,1,0,1,... with no bubbles.
- Backpressure: assert pause for 3 cycles mid-run -> pop=0 for those 3 cycles, slot_ptr frozen; sequence resumes from the same slot without skipping.
- Reconfig mid-run: pulse cfg_load while slot_ptr=6 -> no pop for that slot, one LOAD cycle, slot_ptr=0, new table is used from slot 0.
- Async reset mid-run: drop reset between clock edges with pop=1 -> pop, pop_id and slot_ptr are 0 immediately, and the table reads back as the default pattern afterwards.
